// File: rtl/ram_param_sync.sv
// Parametrised single-port synchronous RAM with registered read and request/valid handshake.
// Define RAM_CLEAR_EN to build the post-reset sweep that fills every word with INIT_VAL.
module ram_param_sync #(
   parameter int unsigned DATA_W   = 4,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DEPTH    = 32,
   parameter logic [31:0] INIT_VAL = 32'h0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req,
   input  logic              wren,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] q,
   output logic              q_valid,
   output logic              busy,
   output logic              drop,
   output logic              oor
);

   localparam int unsigned     IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              in_range;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   logic [DATA_W-1:0] q_q, q_d;
   logic              q_valid_q, q_valid_d;
   logic              drop_q, drop_d;
   logic              oor_q, oor_d;

`ifdef RAM_CLEAR_EN
   localparam logic [DATA_W-1:0] INIT_WORD = INIT_VAL[DATA_W-1:0];
   // Terminal compare on DEPTH-1 so a full 2**ADDR_W array never relies on a wrap.
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {StClear, StReady} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StClear;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StClear: begin
            if (cnt_q == LAST_IDX) begin
               state_d = StReady;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         StReady: begin
            state_d = StReady;
         end
         default: begin
            state_d = StClear;
         end
      endcase
   end

   assign busy = (state_q == StClear);
`else
   assign busy = 1'b0;
`endif

   always_comb begin
      accept    = req & ~busy;
      in_range  = ({1'b0, address} < DEPTH_EXT);
      mem_we    = accept & wren & in_range;
      mem_waddr = address[IDX_W-1:0];
      mem_wdata = data;
      q_d       = q_q;
      q_valid_d = accept;
      oor_d     = accept & ~in_range;
      drop_d    = req & busy;
      if (accept) begin
         if (!in_range) begin
            q_d = '0;
         end else if (wren) begin
            q_d = data;
         end else begin
            q_d = mem[address[IDX_W-1:0]];
         end
      end
`ifdef RAM_CLEAR_EN
      // The sweep owns the write port for as long as busy is high.
      if (busy) begin
         mem_we    = 1'b1;
         mem_waddr = cnt_q[IDX_W-1:0];
         mem_wdata = INIT_WORD;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q_q       <= '0;
         q_valid_q <= 1'b0;
         drop_q    <= 1'b0;
         oor_q     <= 1'b0;
      end else begin
         q_q       <= q_d;
         q_valid_q <= q_valid_d;
         drop_q    <= drop_d;
         oor_q     <= oor_d;
      end
   end

   assign q       = q_q;
   assign q_valid = q_valid_q;
   assign drop    = drop_q;
   assign oor     = oor_q;

endmodule

// File: tb/tb_ram_param_sync.sv
// Bench for ram_param_sync: a full-depth 4-bit instance and a 20-deep 8-bit instance share
// stimulus and are checked against array-based reference memories.
module tb_ram_param_sync;

`ifdef RAM_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif
   localparam int DEPTH_A = 32;
   localparam int DEPTH_B = 20;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       req = 1'b0;
   logic       wren = 1'b0;
   logic [4:0] address = '0;
   logic [7:0] data = '0;

   logic [3:0] q_a;
   logic       qv_a, busy_a, drop_a, oor_a;
   logic [7:0] q_b;
   logic       qv_b, busy_b, drop_b, oor_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_param_sync #(
      .DATA_W(4), .ADDR_W(5), .DEPTH(32), .INIT_VAL(32'hFA)
   ) u_dut_a (
      .clk(clk), .resetn(resetn), .req(req), .wren(wren), .address(address),
      .data(data[3:0]), .q(q_a), .q_valid(qv_a), .busy(busy_a), .drop(drop_a), .oor(oor_a)
   );

   ram_param_sync #(
      .DATA_W(8), .ADDR_W(5), .DEPTH(20), .INIT_VAL(32'h13C)
   ) u_dut_b (
      .clk(clk), .resetn(resetn), .req(req), .wren(wren), .address(address),
      .data(data), .q(q_b), .q_valid(qv_b), .busy(busy_b), .drop(drop_b), .oor(oor_b)
   );

   // Reference model: plain arrays plus a count of sweep words still to be written.
   logic [3:0] mem_a [DEPTH_A];
   bit         kn_a  [DEPTH_A];
   logic [7:0] mem_b [DEPTH_B];
   bit         kn_b  [DEPTH_B];
   int         left_a, left_b;
   logic [3:0] eq_a;
   logic [7:0] eq_b;
   bit         ev_a, eo_a, ed_a, qk_a;
   bit         ev_b, eo_b, ed_b, qk_b;

   function automatic void model_reset();
      eq_a = '0; ev_a = 0; eo_a = 0; ed_a = 0; qk_a = 1;
      eq_b = '0; ev_b = 0; eo_b = 0; ed_b = 0; qk_b = 1;
      left_a = CLEAR_EN ? DEPTH_A : 0;
      left_b = CLEAR_EN ? DEPTH_B : 0;
   endfunction

   function automatic void model_step(bit r, bit w, logic [4:0] a, logic [7:0] d);
      ev_a = 0; eo_a = 0; ed_a = 0;
      if (left_a > 0) begin
         ed_a = r;
         mem_a[DEPTH_A - left_a] = 4'hA;
         kn_a[DEPTH_A - left_a]  = 1;
         left_a--;
      end else if (r) begin
         ev_a = 1;
         if (int'(a) >= DEPTH_A) begin
            eo_a = 1; eq_a = '0; qk_a = 1;
         end else if (w) begin
            mem_a[a] = d[3:0]; kn_a[a] = 1; eq_a = d[3:0]; qk_a = 1;
         end else begin
            eq_a = mem_a[a]; qk_a = kn_a[a];
         end
      end
      ev_b = 0; eo_b = 0; ed_b = 0;
      if (left_b > 0) begin
         ed_b = r;
         mem_b[DEPTH_B - left_b] = 8'h3C;
         kn_b[DEPTH_B - left_b]  = 1;
         left_b--;
      end else if (r) begin
         ev_b = 1;
         if (int'(a) >= DEPTH_B) begin
            eo_b = 1; eq_b = '0; qk_b = 1;
         end else if (w) begin
            mem_b[a] = d; kn_b[a] = 1; eq_b = d; qk_b = 1;
         end else begin
            eq_b = mem_b[a]; qk_b = kn_b[a];
         end
      end
   endfunction

   // Drive one cycle of stimulus, advance the model, sample 1 time unit after the edge.
   task automatic cyc(input bit r, input bit w, input logic [4:0] a, input logic [7:0] d);
      req = r; wren = w; address = a; data = d;
      @(posedge clk);
      model_step(r, w, a, d);
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (q_a !== 4'h0) begin errors++; $display("FAIL rst_q_a got %h want 0", q_a); end
      checks++; if (q_b !== 8'h0) begin errors++; $display("FAIL rst_q_b got %h want 0", q_b); end
      checks++; if (qv_a !== 1'b0 || qv_b !== 1'b0) begin
         errors++; $display("FAIL rst_qv got %b%b want 00", qv_a, qv_b); end
      checks++; if (drop_a !== 1'b0 || oor_b !== 1'b0) begin
         errors++; $display("FAIL rst_pulses drop %b oor %b want 0 0", drop_a, oor_b); end
      checks++; if (busy_a !== CLEAR_EN || busy_b !== CLEAR_EN) begin
         errors++; $display("FAIL rst_busy got %b%b want %b", busy_a, busy_b, CLEAR_EN); end
      @(negedge clk) resetn = 1'b1;
   endtask

`ifdef RAM_CLEAR_EN
   task automatic test_sweep();
      int n_a = 0;
      int n_b = 0;
      for (int i = 0; i < 64 && (busy_a || busy_b); i++) begin
         if (busy_a) n_a++;
         if (busy_b) n_b++;
         cyc(1'b0, 1'b0, 5'd0, 8'h00);
      end
      checks++; if (n_a !== 32) begin errors++; $display("FAIL sweep_len_a got %0d want 32", n_a); end
      checks++; if (n_b !== 20) begin errors++; $display("FAIL sweep_len_b got %0d want 20", n_b); end
      for (int i = 0; i < 32; i++) begin
         cyc(1'b1, 1'b0, 5'(i), 8'h00);
         checks++; if (q_a !== 4'hA || qv_a !== 1'b1) begin
            errors++; $display("FAIL sweep_rd_a[%0d] got %h/%b want a/1", i, q_a, qv_a); end
         checks++; if (q_b !== (i < 20 ? 8'h3C : 8'h00) || oor_b !== (i >= 20)) begin
            errors++; $display("FAIL sweep_rd_b[%0d] got %h oor %b", i, q_b, oor_b); end
      end
   endtask

   task automatic test_mid_sweep();
      int n_a = 0;
      repeat (10) cyc(1'b0, 1'b0, 5'd0, 8'h00);
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy_a); end
      resetn = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      for (int i = 0; i < 64 && busy_a; i++) begin
         n_a++;
         cyc(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom));
         checks++; if (drop_a !== ed_a || drop_b !== ed_b) begin
            errors++; $display("FAIL mid_drop[%0d] got %b%b want %b%b", i, drop_a, drop_b, ed_a, ed_b);
         end
      end
      checks++; if (n_a !== 32) begin errors++; $display("FAIL mid_len got %0d want 32", n_a); end
      for (int i = 0; i < 32; i++) begin
         cyc(1'b1, 1'b0, 5'(i), 8'h00);
         checks++; if (q_a !== 4'hA || qv_a !== 1'b1) begin
            errors++; $display("FAIL mid_rd[%0d] got %h/%b want a/1", i, q_a, qv_a); end
      end
   endtask
`else
   task automatic test_first_access();
      checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
         errors++; $display("FAIL first_busy got %b%b want 00", busy_a, busy_b); end
      cyc(1'b1, 1'b1, 5'd7, 8'h3C);
      checks++; if (q_b !== 8'h3C || qv_b !== 1'b1) begin
         errors++; $display("FAIL first_wr got %h/%b want 3c/1", q_b, qv_b); end
      cyc(1'b1, 1'b0, 5'd7, 8'h00);
      checks++; if (q_b !== 8'h3C || q_a !== 4'hC || busy_a !== 1'b0) begin
         errors++; $display("FAIL first_rd got %h %h busy %b want 3c c 0", q_b, q_a, busy_a); end
   endtask
`endif

   task automatic test_write_read();
      cyc(1'b1, 1'b1, 5'd4, 8'h69);
      cyc(1'b1, 1'b1, 5'd3, 8'h05);
      checks++; if (q_a !== 4'h5 || qv_a !== 1'b1) begin
         errors++; $display("FAIL wr3 got %h/%b want 5/1", q_a, qv_a); end
      cyc(1'b1, 1'b0, 5'd3, 8'h00);
      checks++; if (q_a !== 4'h5 || qv_a !== 1'b1 || q_b !== 8'h05) begin
         errors++; $display("FAIL rd3 got %h/%b %h want 5/1 05", q_a, qv_a, q_b); end
      cyc(1'b0, 1'b0, 5'd9, 8'hFF);
      checks++; if (q_a !== 4'h5 || qv_a !== 1'b0) begin
         errors++; $display("FAIL idle_hold got %h/%b want 5/0", q_a, qv_a); end
      cyc(1'b1, 1'b0, 5'd4, 8'h00);
      checks++; if (q_a !== 4'h9 || q_b !== 8'h69) begin
         errors++; $display("FAIL rd4 got %h %h want 9 69", q_a, q_b); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 64; i++) begin
         cyc(1'b1, i < 32, 5'(i % 32), 8'(i % 32));
         checks++; if (qv_a !== 1'b1 || q_a !== 4'(i % 16)) begin
            errors++; $display("FAIL b2b_a[%0d] got %h/%b want %h/1", i, q_a, qv_a, i % 16); end
         checks++; if (q_b !== ((i % 32) < 20 ? 8'(i % 32) : 8'h00) || oor_b !== ((i % 32) >= 20)) begin
            errors++; $display("FAIL b2b_b[%0d] got %h oor %b", i, q_b, oor_b); end
      end
   endtask

   task automatic test_oor();
      cyc(1'b1, 1'b1, 5'd25, 8'h0F);
      checks++; if (oor_b !== 1'b1 || q_b !== 8'h00 || qv_b !== 1'b1) begin
         errors++; $display("FAIL oor_wr got oor %b q %h v %b want 1 00 1", oor_b, q_b, qv_b); end
      checks++; if (oor_a !== 1'b0 || q_a !== 4'hF) begin
         errors++; $display("FAIL oor_wr_a got oor %b q %h want 0 f", oor_a, q_a); end
      cyc(1'b1, 1'b0, 5'd25, 8'h00);
      checks++; if (oor_b !== 1'b1 || q_b !== 8'h00) begin
         errors++; $display("FAIL oor_rd got oor %b q %h want 1 00", oor_b, q_b); end
      cyc(1'b1, 1'b0, 5'd19, 8'h00);
      checks++; if (oor_b !== 1'b0 || q_b !== 8'd19) begin
         errors++; $display("FAIL oor_edge19 got oor %b q %h want 0 13", oor_b, q_b); end
      cyc(1'b1, 1'b0, 5'd20, 8'h00);
      checks++; if (oor_b !== 1'b1 || q_b !== 8'h00) begin
         errors++; $display("FAIL oor_edge20 got oor %b q %h want 1 00", oor_b, q_b); end
      for (int i = 0; i < DEPTH_B; i++) begin
         cyc(1'b1, 1'b0, 5'(i), 8'h00);
         checks++; if (q_b !== eq_b) begin
            errors++; $display("FAIL oor_keep[%0d] got %h want %h", i, q_b, eq_b); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 8'($urandom));
         checks++; if (qv_a !== ev_a || oor_a !== eo_a || drop_a !== ed_a || busy_a !== (left_a > 0))
         begin
            errors++; $display("FAIL rnd_flags_a[%0d] got %b%b%b%b want %b%b%b%b", i,
                               qv_a, oor_a, drop_a, busy_a, ev_a, eo_a, ed_a, left_a > 0);
         end
         checks++; if (qv_b !== ev_b || oor_b !== eo_b || drop_b !== ed_b || busy_b !== (left_b > 0))
         begin
            errors++; $display("FAIL rnd_flags_b[%0d] got %b%b%b%b want %b%b%b%b", i,
                               qv_b, oor_b, drop_b, busy_b, ev_b, eo_b, ed_b, left_b > 0);
         end
         if (qk_a) begin
            checks++; if (q_a !== eq_a) begin
               errors++; $display("FAIL rnd_q_a[%0d] got %h want %h", i, q_a, eq_a); end
         end
         if (qk_b) begin
            checks++; if (q_b !== eq_b) begin
               errors++; $display("FAIL rnd_q_b[%0d] got %h want %h", i, q_b, eq_b); end
         end
      end
   endtask

   task automatic test_async_reset();
      cyc(1'b1, 1'b1, 5'd9, 8'h77);
      checks++; if (qv_a !== 1'b1 || q_b !== 8'h77) begin
         errors++; $display("FAIL ares_pre got %b %h want 1 77", qv_a, q_b); end
      resetn = 1'b0;
      model_reset();
      #1;
      checks++; if (q_a !== 4'h0 || q_b !== 8'h00 || qv_a !== 1'b0 || qv_b !== 1'b0) begin
         errors++; $display("FAIL ares_out got %h %h %b%b want 0 00 00", q_a, q_b, qv_a, qv_b); end
      checks++; if (busy_a !== CLEAR_EN) begin
         errors++; $display("FAIL ares_busy got %b want %b", busy_a, CLEAR_EN); end
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      if (!CLEAR_EN) begin
         cyc(1'b1, 1'b0, 5'd9, 8'h00);
         checks++; if (q_a !== 4'h7 || q_b !== 8'h77) begin
            errors++; $display("FAIL ares_keep got %h %h want 7 77", q_a, q_b); end
      end
   endtask

   initial begin
      test_reset();
`ifdef RAM_CLEAR_EN
      test_sweep();
`else
      test_first_access();
`endif
      test_write_read();
      test_back_to_back();
      test_oor();
      test_random();
      test_async_reset();
`ifdef RAM_CLEAR_EN
      test_mid_sweep();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached without finishing, want completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ram_param_sync.md
# ram_param_sync

Parametrised single-port synchronous RAM with registered read, a request/valid handshake, and an optional post-reset clear sweep. It is the generalised successor of the fixed 32x4 lab RAM: width, depth and initial fill value are parameters. It sits between board-level switch/key decoding and the hex display decoders, or behind any small controller that needs scratch storage.

## Interface
- DATA_W, 4, word width in bits (1..32)
- ADDR_W, 5, address width in bits (1..12)
- DEPTH, 32, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
- INIT_VAL, 0, word value written by the clear sweep (truncated to DATA_W)

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- req  in  1  access request, sampled on rising clk
- wren  in  1  1 = write, 0 = read; qualified by req
- address  in  ADDR_W  word address
- data  in  DATA_W  write data
- q  out  DATA_W  registered read data
- q_valid  out  1  one-cycle pulse: q updated by an accepted access
- busy  out  1  high while the clear sweep runs; requests are not accepted
- drop  out  1  one-cycle pulse: a request arrived while busy and was discarded
- oor  out  1  one-cycle pulse: accepted request had address >= DEPTH

## Operation
- States: CLEAR, READY. Reset enters CLEAR when RAM_CLEAR_EN is defined, READY otherwise.
- CLEAR: sweep counter starts at 0. Each cycle writes INIT_VAL to mem[counter] and increments. Counter equals DEPTH-1 on the last write; the next state is READY. Requests are ignored and pulse drop.
- READY: req=1 accepts the access in that cycle.
  - Write (wren=1, address<DEPTH): mem[address] <= data, q <= data (write-first), q_valid pulses.
  - Read (wren=0, address<DEPTH): q <= mem[address], q_valid pulses.
  - address >= DEPTH: memory is unchanged, q <= 0, q_valid and oor pulse.
- req=0: q holds its value. q_valid, drop and oor are 0.
- Memory contents are not reset by resetn. Only the sweep initialises them.
- Sweep counter width is ADDR_W. For DEPTH = 2**ADDR_W, the terminal compare is on DEPTH-1, not a wrap to 0.

## Timing
- Reset values: q=0, q_valid=0, drop=0, oor=0. busy=1 with RAM_CLEAR_EN, busy=0 without it.
- Read and write latency: 1 cycle. A request sampled at edge N gives q/q_valid valid after edge N.
- Throughput: one access per cycle. Back-to-back requests are allowed with no bubbles.
- Read of address A one cycle after a write to A returns the new data.
- Sweep duration: busy is high for DEPTH cycles after the first rising clk following resetn release. busy falls after the edge that writes word DEPTH-1.
- resetn asserted mid-sweep or mid-access: outputs go to reset values immediately (asynchronously). The sweep restarts at word 0 after release. An interrupted write has undefined effect on that one word only.
- A request on the same cycle busy falls is dropped. The first accepted request comes on the cycle after busy=0 is observed.

## Configuration
- RAM_CLEAR_EN defined:
  - CLEAR state and sweep counter are built.
  - After every reset, all DEPTH words read INIT_VAL until written.
- RAM_CLEAR_EN undefined:
  - No sweep logic is built.
  - busy is tied to 0 and drop never pulses.
  - Power-up contents are undefined.
  - The block is accepting from the first clk after reset.

## Test plan
- RAM_CLEAR_EN, DEPTH=32, INIT_VAL=4'hA: release reset, count busy-high cycles, then read all 32 addresses. Required: exactly 32 busy cycles, then q=4'hA with q_valid on every read.
- Write 4'h5 to address 3, then read address 3 on the next cycle. Required: q=4'h5 with q_valid after the write and again after the read. Address 4 stays unchanged.
- Back-to-back writes to addresses 0..31 with data=address[3:0], followed by 32 back-to-back reads. Required: q sequence 0,1,..,F,0,..,F with q_valid high for 64 consecutive cycles.
- DEPTH=20, ADDR_W=5: write 4'hF to address 25, then read address 25. Required: oor pulses twice, q=0 on both, and addresses 0..19 are unaltered.
- Assert resetn low at sweep word 10, hold for 2 cycles, then release; issue req during busy. Required: busy again lasts 32 cycles, drop pulses for each request issued while busy, and all words read INIT_VAL.
- RAM_CLEAR_EN undefined, DATA_W=8: write 8'h3C to address 7 on the first post-reset cycle, then read it back. Required: busy=0 throughout, q=8'h3C.
